// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the divider requester
package div_pkg;

    localparam int DIV_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLD      = 3'd4
    } state_e;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_DIV0    = 2'b01;
    localparam logic [1:0] ERR_ACK_TO  = 2'b10;
    localparam logic [1:0] ERR_DONE_TO = 2'b11;

endpackage

// File: rtl/div_watchdog.sv
// rtl/div_watchdog.sv - saturating cycle counter with acknowledge and completion limits
module div_watchdog #(
    parameter int ACK_MAX  = 4,
    parameter int DONE_MAX = 255
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clr_i,
    input  logic en_i,
    output logic ack_expired_o,
    output logic done_expired_o
);

    localparam int MAX_LIM = (ACK_MAX > DONE_MAX) ? ACK_MAX : DONE_MAX;
    localparam int CW      = $clog2(MAX_LIM + 1);

    localparam logic [CW-1:0] ACK_LIM  = CW'(ACK_MAX);
    localparam logic [CW-1:0] DONE_LIM = CW'(DONE_MAX);
    localparam logic [CW-1:0] SAT_LIM  = CW'(MAX_LIM);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins over counting; the count sticks at the largest limit so it never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != SAT_LIM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ack_expired_o  = (cnt_q >= ACK_LIM);
    assign done_expired_o = (cnt_q >= DONE_LIM);

endmodule

// File: rtl/div_requester.sv
// rtl/div_requester.sv - requester-side sequencer for the shift-subtract divider
module div_requester
    import div_pkg::*;
#(
    parameter int W        = DIV_W,
    parameter int ACK_MAX  = 4,
    parameter int DONE_MAX = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         div_start,
    output logic [W-1:0] div_a,
    output logic [W-1:0] div_b,
    input  logic         div_busy,
    input  logic [W-1:0] div_quot,
    input  logic [W-1:0] div_rem,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem,
    output logic [1:0]   err
);

    state_e         state_q, state_d;
    logic           req_ready_q, req_ready_d;
    logic           div_start_q, div_start_d;
    logic           res_valid_q, res_valid_d;
    logic [W-1:0]   div_a_q, div_a_d;
    logic [W-1:0]   div_b_q, div_b_d;
    logic [W-1:0]   quot_q, quot_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [1:0]     err_q, err_d;

    logic           wd_clr;
    logic           wd_en;
    logic           ack_expired;
    logic           done_expired;

    // The watchdog restarts on every state change and only runs while waiting on the divider.
    assign wd_clr = (state_d != state_q);
    assign wd_en  = (state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_DONE);

    div_watchdog #(
        .ACK_MAX  (ACK_MAX),
        .DONE_MAX (DONE_MAX)
    ) u_watchdog (
        .clk_i          (clk),
        .rstn_i         (rst),
        .clr_i          (wd_clr),
        .en_i           (wd_en),
        .ack_expired_o  (ack_expired),
        .done_expired_o (done_expired)
    );

    // Next state and next values of every registered output.
    always_comb begin
        state_d = state_q;
        div_a_d = div_a_q;
        div_b_d = div_b_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        err_d   = ERR_DIV0;
                        state_d = ST_HOLD;
                    end else begin
                        div_a_d = dividend;
                        div_b_d = divisor;
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (div_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (ack_expired) begin
                    quot_d  = '0;
                    rem_d   = '0;
                    err_d   = ERR_ACK_TO;
                    state_d = ST_HOLD;
                end
            end
            ST_WAIT_DONE: begin
                if (!div_busy) begin
                    quot_d  = div_quot;
                    rem_d   = div_rem;
                    err_d   = ERR_OK;
                    state_d = ST_HOLD;
                end else if (done_expired) begin
                    quot_d  = '0;
                    rem_d   = '0;
                    err_d   = ERR_DONE_TO;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (res_valid_q && res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs follow the state being entered, so they are valid on arrival.
        req_ready_d = (state_d == ST_IDLE) && !div_busy;
        div_start_d = (state_d == ST_WAIT_ACK);
        res_valid_d = (state_d == ST_HOLD);
    end

    // State and output registers; reset abandons any division in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            div_start_q <= 1'b0;
            res_valid_q <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            err_q       <= ERR_OK;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            div_start_q <= div_start_d;
            res_valid_q <= res_valid_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            err_q       <= err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign div_start = div_start_q;
    assign res_valid = res_valid_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign quot      = quot_q;
    assign rem       = rem_q;
    assign err       = err_q;

endmodule

// File: doc/div_requester.md
# div_requester

Sequencer that drives the shift-subtract divider's start/BUSY handshake from the requesting side on behalf of the position datapath. It accepts a dividend/divisor pair over a valid/ready port, launches one division, and captures quotient and remainder when BUSY falls. It returns the result over a second valid/ready port. Divide-by-zero is resolved locally without touching the divider, and a watchdog flags a divider that never acknowledges or never finishes.

## Interface
- W, 16: operand and result width.
- ACK_MAX, 4: cycles allowed in WAIT_ACK for div_busy to rise.
- DONE_MAX, 255: cycles allowed in WAIT_DONE for div_busy to fall.

- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-low.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when high with req_valid.
- dividend  in  W  request dividend.
- divisor  in  W  request divisor.
- div_start  out  1  start to divider.
- div_a  out  W  dividend to divider, held from launch until capture.
- div_b  out  W  divisor to divider, held from launch until capture.
- div_busy  in  1  divider BUSY.
- div_quot  in  W  divider quotient.
- div_rem  in  W  divider remainder.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when high with res_valid.
- quot  out  W  result quotient.
- rem  out  W  result remainder.
- err  out  2  00 OK, 01 DIV0, 10 ACK_TIMEOUT, 11 DONE_TIMEOUT.

## Operation
- States: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, HOLD.
- Reset (rst==0 at an edge): state IDLE, watchdog 0.
  - All outputs 0: req_ready, div_start, div_a, div_b, res_valid, quot, rem, err.
  - Any in-flight division is abandoned and its result is never presented.
- IDLE:
  - req_ready = !div_busy. A divider still busy, including while in its own reset state, blocks acceptance.
  - On accept with divisor==0: register quot = all ones, rem = dividend, err = DIV0, then go to HOLD. The divider is not started.
  - On accept with divisor!=0: register div_a and div_b, go to LAUNCH.
- LAUNCH: div_start = 1 and the watchdog clears. Go to WAIT_ACK.
- WAIT_ACK:
  - div_start stays 1 until div_busy==1 is sampled, then go to WAIT_DONE with div_start = 0.
  - If the watchdog reaches ACK_MAX: err = ACK_TIMEOUT, quot = rem = 0, div_start = 0, go to HOLD.
- WAIT_DONE:
  - div_start = 0.
  - When div_busy==0 is sampled: register quot = div_quot, rem = div_rem, err = OK, go to HOLD.
  - If the watchdog reaches DONE_MAX first: err = DONE_TIMEOUT, quot = rem = 0, go to HOLD.
- HOLD:
  - res_valid = 1. quot, rem and err are stable; req_ready = 0.
  - On res_valid & res_ready, go to IDLE with res_valid = 0.
  - Back-pressure may last indefinitely. The watchdog is idle in HOLD.
- All outputs are registered. The watchdog is a saturating counter that clears on every state change.

## Timing
- Request accepted at edge T: LAUNCH during T..T+1, and div_start is high from T+1.
- Divider BUSY normally rises two cycles after div_start does. Start is dropped in the cycle after busy is sampled high.
  - The divider ignores start outside its IDLE state, so the one-cycle overlap is harmless.
  - Start is never high while the divider is back in IDLE after finishing, so no double launch.
- Capture happens at the first edge sampling div_busy==0 in WAIT_DONE. res_valid rises the following cycle.
- Divide-by-zero: res_valid is high the cycle after the accept edge (latency 1).
- Minimum spacing between accepts is one IDLE cycle after the res handshake.
- If res_valid & res_ready occurs while req_valid is high, the new request is not accepted in that same cycle.

## Structure
- Shared package div_pkg holds the state enum, the err code constants (ERR_OK, ERR_DIV0, ERR_ACK_TO, ERR_DONE_TO) and the default W.
- Sub-module div_watchdog: saturating counter with clear and two compare outputs (ack_expired, done_expired).
- All other logic is one FSM plus output registers in div_requester.

## Test plan
- 100/7 with divider model BUSY=1 for 20 cycles -> div_start high exactly 3 cycles; quot=14, rem=2, err=00, res_valid one cycle after BUSY falls.
- 55/0 -> div_start never asserted; quot=16'hFFFF, rem=55, err=01, res_valid at T+1.
- Divider model never raises BUSY -> div_start high ACK_MAX+1 cycles then low; err=10, quot=rem=0.
- BUSY stuck high after launch -> err=11 at DONE_MAX; holding res_ready=0 for 50 cycles keeps res_valid, quot, rem and err stable and req_ready low.
- rst=0 during WAIT_DONE -> next cycle all outputs 0; after release a 9/3 request returns quot=3, rem=0, and the stale result is never presented.
- div_busy held 1 at idle (divider in reset) with req_valid=1 -> req_ready=0 and no accept until busy drops.
